multicycle_control_unit: RTL and testbench

Finite-state controller that sequences a multi-cycle version of the MIPS datapath, where instruction fetch and data access share one memory port and the ALU is reused across cycles. It decodes the instruction held in the datapath's instruction register (IR) and drives every datapath enable and mux select. It covers add, sub, and, or, slt, sll, lw, sw and beq. It waits on a variable-latency memory through a ready handshake and reports retired-instruction and trap status.

---
 rtl/multicycle_control_unit_if.sv | 52 +++++
 rtl/multicycle_control_unit.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Bus between the multicycle MIPS controller and its datapath.
//   master: controller side (drives enables/selects/status, receives decode fields and flags)
//   slave : datapath side (mirror image)
// Signals:
//   opcode, funct    IR[31:26], IR[5:0]
//   alu_zero         ALU zero flag
//   mem_ready        memory completes the current access this cycle
//   pc_write .. alu_op  datapath enables and mux selects
//   retire           one-cycle pulse when an instruction completes
//   instr_count      retired-instruction count (wraps)
//   trap             illegal instruction seen (held until reset)
//   state            current controller state (debug)
interface multicycle_control_unit_if #(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned COUNT_W = 32
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               alu_zero;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               pc_source;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [2:0]         alu_op;
    logic               retire;
    logic [COUNT_W-1:0] instr_count;
    logic               trap;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, retire,
               instr_count, trap, state
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, retire,
               instr_count, trap, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: sequences fetch/decode/execute over a shared memory port,
// decodes add/sub/and/or/slt/sll/lw/sw/beq, waits on mem_ready, counts retired
// instructions and parks in a trap state on an illegal instruction.
// Ports:
//   clock  system clock; state and counter update on the falling edge
//   clear  asynchronous active-low reset; forces every output to 0 while low
//   bus    controller side of multicycle_control_unit_if
module multicycle_control_unit #(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned COUNT_W = 32
) (
    input logic                       clock,
    input logic                       clear,
    multicycle_control_unit_if.master bus
);
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSll = 3'b011;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StTrap     = 4'd9
    } state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               retire;

    // The branch decision is made in the datapath (pc_write_cond & alu_zero).
    logic unused_alu_zero;
    assign unused_alu_zero = bus.alu_zero;

    function automatic logic legal_funct(input logic [5:0] f);
        return (f == 6'h00) || (f == 6'h20) || (f == 6'h22) ||
               (f == 6'h24) || (f == 6'h25) || (f == 6'h2a);
    endfunction

    function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
        logic [2:0] op;
        op = AluAnd;
        unique case (f)
            6'h20:   op = AluAdd;
            6'h22:   op = AluSub;
            6'h24:   op = AluAnd;
            6'h25:   op = AluOr;
            6'h2a:   op = AluSlt;
            6'h00:   op = AluSll;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    always_comb begin
        state_d           = state_q;
        retire            = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 2'd0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = AluAnd;
        bus.trap          = 1'b0;

        unique case (state_q)
            StFetch: begin
                // PC + 4 computed every fetch cycle, committed only with the IR load.
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.alu_op    = AluAdd;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = StDecode;
                end
            end
            StDecode: begin
                // Speculative branch target into ALUOut.
                bus.alu_src_b = 2'd3;
                bus.alu_op    = AluAdd;
                if (bus.opcode == OpLw || bus.opcode == OpSw) begin
                    state_d = StMemAddr;
                end else if (bus.opcode == OpBeq) begin
                    state_d = StBranch;
                end else if (bus.opcode == OpRtype && legal_funct(bus.funct)) begin
                    state_d = StExecute;
                end else begin
                    state_d = StTrap;
                end
            end
            StMemAddr: begin
                bus.alu_src_a = 2'd1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = AluAdd;
                if (bus.opcode == OpLw) begin
                    state_d = StMemRead;
                end else if (bus.opcode == OpSw) begin
                    state_d = StMemWrite;
                end else begin
                    // IR changed under us; refuse to guess.
                    state_d = StTrap;
                end
            end
            StMemRead: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
                state_d        = StFetch;
            end
            StMemWrite: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecute: begin
                bus.alu_op    = funct_alu_op(bus.funct);
                bus.alu_src_a = (bus.funct == 6'h00) ? 2'd2 : 2'd1;
                bus.alu_src_b = 2'd0;
                state_d       = StAluWb;
            end
            StAluWb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                bus.alu_src_a     = 2'd1;
                bus.alu_src_b     = 2'd0;
                bus.alu_op        = AluSub;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 1'b1;
                retire            = 1'b1;
                state_d           = StFetch;
            end
            StTrap: begin
                bus.trap = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset silences the datapath, including the fetch read request.
        if (!clear) begin
            retire            = 1'b0;
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.pc_source     = 1'b0;
            bus.i_or_d        = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.ir_write      = 1'b0;
            bus.mem_to_reg    = 1'b0;
            bus.reg_dst       = 1'b0;
            bus.reg_write     = 1'b0;
            bus.alu_src_a     = 2'd0;
            bus.alu_src_b     = 2'd0;
            bus.alu_op        = AluAnd;
            bus.trap          = 1'b0;
        end

        bus.retire      = retire;
        count_d         = count_q + COUNT_W'(retire);
        bus.instr_count = count_q;
        bus.state       = STATE_W'(state_q);
    end

    always_ff @(negedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StFetch;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized scoreboard bench for multicycle_control_unit. Each instruction is expanded into
// a per-cycle plan from the instruction-level rules (cycle kinds, stall counts); the driver
// pushes each cycle's expectation as it drives it and a posedge monitor pops and compares.
module tb_multicycle_control_unit;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned COUNT_W = 4;  // narrow so the wrap happens during the run

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic       retire;
        logic       trap;
    } ctrl_t;

    typedef struct packed {
        logic       clear;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       alu_zero;
        logic       mem_ready;
        logic [3:0] state;
        ctrl_t      ctrl;
    } cyc_t;

    typedef struct packed {
        logic [3:0]         state;
        ctrl_t              ctrl;
        logic [COUNT_W-1:0] count;
    } exp_t;

    logic  clock = 1'b0;
    logic  clear;
    cyc_t  plan[$];
    exp_t  sb[$];
    exp_t  e;
    ctrl_t act;
    int    compared = 0;
    int    mismatched = 0;
    int    exp_count = 0;

    multicycle_control_unit_if #(.STATE_W(STATE_W), .COUNT_W(COUNT_W)) bus ();

    multicycle_control_unit #(.STATE_W(STATE_W), .COUNT_W(COUNT_W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic bit legal_fn(input logic [5:0] f);
        return f == 6'h00 || f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a;
    endfunction

    function automatic logic [2:0] op_of(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b011;
        endcase
    endfunction

    task automatic push_cyc(input logic [3:0] st, input ctrl_t c, input logic ready,
                            input logic [5:0] op, input logic [5:0] fn);
        cyc_t x;
        x.clear = 1'b1; x.opcode = op; x.funct = fn; x.alu_zero = 1'($urandom);
        x.mem_ready = ready; x.state = st; x.ctrl = c;
        plan.push_back(x);
    endtask

    task automatic push_reset(input logic ready);
        cyc_t x;
        x = '0;
        x.opcode = 6'($urandom); x.funct = 6'($urandom); x.mem_ready = ready;
        plan.push_back(x);
    endtask

    // Expand one instruction into its cycle plan; returns 1 if it ends in the trap state.
    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input int fstall,
                             input int mstall, input int trap_len, output bit trapped);
        ctrl_t c;
        trapped = 0;
        plan.delete();
        c = '0; c.mem_read = 1; c.src_b = 2'd1; c.alu_op = 3'b010;
        for (int i = 0; i < fstall; i++) push_cyc(4'd0, c, 1'b0, 6'($urandom), 6'($urandom));
        c.ir_write = 1; c.pc_write = 1;
        push_cyc(4'd0, c, 1'b1, 6'($urandom), 6'($urandom));
        c = '0; c.src_b = 2'd3; c.alu_op = 3'b010;
        push_cyc(4'd1, c, 1'($urandom), op, fn);
        if (op == 6'h23 || op == 6'h2b) begin
            c = '0; c.src_a = 2'd1; c.src_b = 2'd2; c.alu_op = 3'b010;
            push_cyc(4'd2, c, 1'($urandom), op, fn);
            c = '0; c.i_or_d = 1;
            if (op == 6'h23) begin
                c.mem_read = 1;
                for (int i = 0; i <= mstall; i++) push_cyc(4'd3, c, 1'(i == mstall), op, fn);
                c = '0; c.reg_write = 1; c.mem_to_reg = 1; c.retire = 1;
                push_cyc(4'd4, c, 1'($urandom), op, fn);
            end else begin
                c.mem_write = 1;
                for (int i = 0; i < mstall; i++) push_cyc(4'd5, c, 1'b0, op, fn);
                c.retire = 1;
                push_cyc(4'd5, c, 1'b1, op, fn);
            end
        end else if (op == 6'h04) begin
            c = '0; c.src_a = 2'd1; c.alu_op = 3'b110; c.pc_write_cond = 1; c.pc_source = 1;
            c.retire = 1;
            push_cyc(4'd8, c, 1'($urandom), op, fn);
        end else if (op == 6'h00 && legal_fn(fn)) begin
            c = '0; c.alu_op = op_of(fn); c.src_a = (fn == 6'h00) ? 2'd2 : 2'd1;
            push_cyc(4'd6, c, 1'($urandom), op, fn);
            c = '0; c.reg_write = 1; c.reg_dst = 1; c.retire = 1;
            push_cyc(4'd7, c, 1'($urandom), op, fn);
        end else begin
            c = '0; c.trap = 1;
            for (int i = 0; i < trap_len; i++) push_cyc(4'd9, c, 1'($urandom), op, fn);
            trapped = 1;
        end
    endtask

    // Called just after a falling edge: drive each cycle, then wait for the next falling edge.
    task automatic run_plan();
        exp_t x;
        foreach (plan[i]) begin
            clear         = plan[i].clear;
            bus.opcode    = plan[i].opcode;
            bus.funct     = plan[i].funct;
            bus.alu_zero  = plan[i].alu_zero;
            bus.mem_ready = plan[i].mem_ready;
            if (!plan[i].clear) exp_count = 0;
            x.state = plan[i].state;
            x.ctrl  = plan[i].ctrl;
            x.count = COUNT_W'(exp_count);
            sb.push_back(x);
            @(negedge clock);
            #1;
            if (plan[i].clear && plan[i].ctrl.retire) exp_count = (exp_count + 1) % (1 << COUNT_W);
        end
    endtask

    always @(posedge clock) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act.pc_write = bus.pc_write;       act.pc_write_cond = bus.pc_write_cond;
            act.pc_source = bus.pc_source;     act.i_or_d = bus.i_or_d;
            act.mem_read = bus.mem_read;       act.mem_write = bus.mem_write;
            act.ir_write = bus.ir_write;       act.mem_to_reg = bus.mem_to_reg;
            act.reg_dst = bus.reg_dst;         act.reg_write = bus.reg_write;
            act.src_a = bus.alu_src_a;         act.src_b = bus.alu_src_b;
            act.alu_op = bus.alu_op;           act.retire = bus.retire;
            act.trap = bus.trap;
            compared++;
            if (bus.state !== e.state) begin
                mismatched++;
                $display("FAIL state @%0t: got %0d want %0d", $time, bus.state, e.state);
            end
            compared++;
            if (act !== e.ctrl) begin
                mismatched++;
                $display("FAIL ctrl @%0t state %0d: got %b want %b", $time, e.state, act, e.ctrl);
            end
            compared++;
            if (bus.instr_count !== e.count) begin
                mismatched++;
                $display("FAIL instr_count @%0t: got %0d want %0d", $time, bus.instr_count,
                         e.count);
            end
            compared++;
            if (bus.mem_read && bus.mem_write) begin
                mismatched++;
                $display("FAIL mem_excl @%0t: got read=1 write=1 want not both", $time);
            end
        end
    end

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fstall,
                            input int mstall, input int trap_len, input int abort_at);
        bit trapped;
        gen_instr(op, fn, fstall, mstall, trap_len, trapped);
        if (abort_at > 0 && abort_at < plan.size()) begin
            while (plan.size() > abort_at) void'(plan.pop_back());
            push_reset(1'($urandom));
        end else if (trapped) begin
            push_reset(1'b1);
        end
        run_plan();
    endtask

    initial begin
        logic [5:0] functs[6];
        logic [5:0] op, fn;
        int         k;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
        clear = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;

        plan.delete();
        for (int i = 0; i < 3; i++) push_reset(1'b1);
        run_plan();

        do_instr(6'h00, 6'h20, 0, 0, 0, 0);   // add
        do_instr(6'h00, 6'h00, 0, 0, 0, 0);   // sll
        do_instr(6'h23, 6'h11, 0, 0, 0, 0);   // lw
        do_instr(6'h2b, 6'h05, 0, 2, 0, 0);   // sw, two stall cycles
        do_instr(6'h04, 6'h07, 0, 0, 0, 0);   // beq
        do_instr(6'h00, 6'h22, 3, 0, 0, 0);   // sub after 3-cycle fetch stall
        do_instr(6'h3f, 6'h00, 0, 0, 10, 0);  // illegal opcode, then clear

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 15);
            fn = 6'($urandom);
            if (k <= 5 || k >= 14) begin
                op = 6'h00; fn = functs[$urandom_range(0, 5)];
            end else if (k <= 7) op = 6'h23;
            else if (k <= 9) op = 6'h2b;
            else if (k <= 11) op = 6'h04;
            else if (k == 12) begin
                op = 6'($urandom);
                while (op == 6'h00 || op == 6'h04 || op == 6'h23 || op == 6'h2b) op = 6'($urandom);
            end else begin
                op = 6'h00;
                while (legal_fn(fn)) fn = 6'($urandom);
            end
            do_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 4),
                     ($urandom_range(0, 11) == 0) ? $urandom_range(1, 6) : 0);
        end

        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
